// File: rtl/chacha_ks_scheduler.sv
// Round-robin scheduler that time-shares one ChaCha keystream unit among N_REQ lanes,
// each lane owning a nonce and a 32-bit block counter.
module chacha_ks_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned LW      = 2,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [255:0]          key,
  input  logic [N_REQ*96-1:0]   lane_nonce,
  input  logic [N_REQ*32-1:0]   lane_ctr_init,
  input  logic [N_REQ-1:0]      lane_load,
  input  logic [N_REQ-1:0]      req,
  output logic                  resp_valid,
  output logic [LW-1:0]         resp_lane,
  output logic [511:0]          resp_data,
  output logic [31:0]           resp_ctr,
  output logic                  resp_err,
  output logic [N_REQ-1:0]      exhausted,
  output logic                  busy,
  output logic                  ks_cfg_we,
  output logic [255:0]          ks_key,
  output logic [95:0]           ks_nonce,
  output logic [31:0]           ks_ctr,
  output logic                  ks_req,
  input  logic                  ks_valid,
  input  logic [511:0]          ks_data
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_REQ, S_DONE} state_t;

  state_t           state;
  logic [LW-1:0]    g;
  logic [LW-1:0]    rr_ptr;
  logic [31:0]      ctr [N_REQ];
  logic [31:0]      cur_ctr;
  logic [TW-1:0]    tmo;

  logic [N_REQ-1:0] eligible;
  logic             grant_found;
  logic [LW-1:0]    grant_lane;
  logic [LW-1:0]    scan_lane;

  // Scan from lowest to highest priority so the last hit (offset 1 from rr_ptr) wins.
  always_comb begin
    eligible    = req & ~exhausted;
    grant_found = 1'b0;
    grant_lane  = '0;
    scan_lane   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_lane = LW'((32'(rr_ptr) + N_REQ - k) % N_REQ);
      if (eligible[scan_lane]) begin
        grant_found = 1'b1;
        grant_lane  = scan_lane;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      g          <= '0;
      rr_ptr     <= LW'(N_REQ - 1);
      for (int unsigned i = 0; i < N_REQ; i++) ctr[i] <= '0;
      cur_ctr    <= '0;
      tmo        <= '0;
      exhausted  <= '0;
      resp_valid <= 1'b0;
      resp_lane  <= '0;
      resp_data  <= '0;
      resp_ctr   <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      ks_cfg_we  <= 1'b0;
      ks_key     <= '0;
      ks_nonce   <= '0;
      ks_ctr     <= '0;
      ks_req     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            g         <= grant_lane;
            busy      <= 1'b1;
            ks_cfg_we <= 1'b1;
            ks_key    <= key;
            ks_nonce  <= lane_nonce[96*grant_lane +: 96];
            ks_ctr    <= ctr[grant_lane];
            cur_ctr   <= ctr[grant_lane];
            state     <= S_CFG;
          end
        end
        S_CFG: begin
          ks_cfg_we <= 1'b0;
          ks_req    <= 1'b1;
          tmo       <= '0;
          state     <= S_REQ;
        end
        S_REQ: begin
          if (ks_valid) begin
            ks_req     <= 1'b0;
            resp_valid <= 1'b1;
            resp_lane  <= g;
            resp_data  <= ks_data;
            resp_ctr   <= cur_ctr;
            resp_err   <= 1'b0;
            state      <= S_DONE;
          end else if (tmo == TW'(TIMEOUT - 1)) begin
            ks_req     <= 1'b0;
            resp_valid <= 1'b1;
            resp_lane  <= g;
            resp_data  <= '0;
            resp_ctr   <= cur_ctr;
            resp_err   <= 1'b1;
            state      <= S_DONE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_DONE: begin
          rr_ptr <= g;
          busy   <= 1'b0;
          state  <= S_IDLE;
          if (!resp_err) begin
            ctr[g] <= ctr[g] + 32'd1;
            if (ctr[g] == '1) exhausted[g] <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      // Placed after the FSM so a same-cycle load overrides the post-block increment.
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (lane_load[i]) begin
          ctr[i]       <= lane_ctr_init[32*i +: 32];
          exhausted[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_chacha_ks_scheduler.sv
// Bench for chacha_ks_scheduler: stub keystream unit plus a queue of expected responses.
module tb_chacha_ks_scheduler;

  localparam int N   = 4;
  localparam int TMO = 256;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [255:0]    key;
  logic [N*96-1:0] lane_nonce;
  logic [N*32-1:0] lane_ctr_init;
  logic [N-1:0]    lane_load, req;
  logic            resp_valid, resp_err, busy, ks_cfg_we, ks_req;
  logic [1:0]      resp_lane;
  logic [511:0]    resp_data;
  logic [31:0]     resp_ctr, ks_ctr;
  logic [N-1:0]    exhausted;
  logic [255:0]    ks_key;
  logic [95:0]     ks_nonce;
  logic            ks_valid;
  logic [511:0]    ks_data;

  chacha_ks_scheduler #(.N_REQ(N), .LW(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .lane_nonce(lane_nonce),
    .lane_ctr_init(lane_ctr_init), .lane_load(lane_load), .req(req),
    .resp_valid(resp_valid), .resp_lane(resp_lane), .resp_data(resp_data),
    .resp_ctr(resp_ctr), .resp_err(resp_err), .exhausted(exhausted), .busy(busy),
    .ks_cfg_we(ks_cfg_we), .ks_key(ks_key), .ks_nonce(ks_nonce), .ks_ctr(ks_ctr),
    .ks_req(ks_req), .ks_valid(ks_valid), .ks_data(ks_data)
  );

  always #5 clk = ~clk;

  // Stub unit: latches context on cfg_we, answers 20 cycles into a request when enabled.
  logic        stub_en;
  logic [95:0] st_nonce;
  logic [31:0] st_ctr;
  int          lat_cnt;
  always @(posedge clk) begin
    ks_valid <= 1'b0;
    if (ks_cfg_we) begin
      st_nonce <= ks_nonce;
      st_ctr   <= ks_ctr;
    end
    if (ks_req && !ks_valid && stub_en) begin
      if (lat_cnt == 19) begin
        ks_valid <= 1'b1;
        ks_data  <= {16{st_nonce[31:0] ^ st_ctr}};
        lat_cnt  <= 0;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
    end
  end

  typedef struct packed {
    logic [1:0]   lane;
    logic [31:0]  ctr;
    logic         err;
    logic [511:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] mctr [N];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic exp_t mk(input int lane, input logic [31:0] c, input logic err);
    exp_t r;
    logic [31:0] lo;
    lo     = lane_nonce[96*lane +: 32];
    r.lane = 2'(lane);
    r.ctr  = c;
    r.err  = err;
    r.data = err ? '0 : {16{lo ^ c}};
    return r;
  endfunction

  task automatic push_exp(input int lane, input logic err);
    sb.push_back(mk(lane, mctr[lane], err));
    if (!err) mctr[lane] = mctr[lane] + 32'd1;
  endtask

  task automatic wait_cfg(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (ks_cfg_we) ok = 1'b1;
    end
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (resp_valid) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; lane_load = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) mctr[i] = '0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({resp_valid, busy, ks_req, ks_cfg_we, resp_err, exhausted} !== 9'b0)
      $display("FAIL reset_ctrl: got %b expected 0",
               {resp_valid, busy, ks_req, ks_cfg_we, resp_err, exhausted});
    else n_pass++;
    n_checks++;
    if ({resp_data, resp_ctr, ks_ctr, resp_lane} !== '0)
      $display("FAIL reset_data: got ctr=%h ks_ctr=%h lane=%0d expected 0", resp_ctr, ks_ctr, resp_lane);
    else n_pass++;
  endtask

  task automatic test_single_lane();
    bit ok;
    lane_ctr_init[31:0] = 32'd5; lane_load = 4'b0001;
    mctr[0] = 32'd5;
    @(negedge clk);
    lane_load = '0;
    for (int b = 0; b < 3; b++) push_exp(0, 1'b0);
    req = 4'b0001;
    for (int b = 0; b < 3; b++) begin
      wait_cfg(ok);
      n_checks++;
      if (!ok) $display("FAIL single_cfg: no ks_cfg_we within bound");
      else if ({ks_req, busy, ks_ctr, ks_nonce} !== {1'b0, 1'b1, sb[0].ctr, lane_nonce[95:0]})
        $display("FAIL single_cfg: got req=%b busy=%b ks_ctr=%h expected req=0 busy=1 ks_ctr=%h",
                 ks_req, busy, ks_ctr, sb[0].ctr);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({ks_req, ks_cfg_we} !== 2'b10)
        $display("FAIL single_req_after_cfg: got req=%b cfg_we=%b expected req=1 cfg_we=0", ks_req, ks_cfg_we);
      else n_pass++;
      wait_resp(ok);
      e = sb.pop_front();
      if (b == 2) req = '0;
      n_checks++;
      if (!ok) $display("FAIL single_resp: no resp_valid within bound");
      else if ({resp_lane, resp_ctr, resp_err, resp_data} !== {e.lane, e.ctr, e.err, e.data})
        $display("FAIL single_resp: got lane=%0d ctr=%h err=%b data_lo=%h expected lane=%0d ctr=%h err=%b data_lo=%h",
                 resp_lane, resp_ctr, resp_err, resp_data[31:0], e.lane, e.ctr, e.err, e.data[31:0]);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int b = 0; b < 5; b++) push_exp(order[b], 1'b0);
    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      wait_resp(ok);
      e = sb.pop_front();
      if (b == 4) req = '0;
      n_checks++;
      if (!ok) $display("FAIL rr_resp: no resp_valid within bound");
      else if ({resp_lane, resp_ctr, resp_err, resp_data} !== {e.lane, e.ctr, e.err, e.data})
        $display("FAIL rr_resp: got lane=%0d ctr=%h err=%b expected lane=%0d ctr=%h err=%b",
                 resp_lane, resp_ctr, resp_err, e.lane, e.ctr, e.err);
      else n_pass++;
    end
  endtask

  task automatic test_exhaust();
    bit ok, seen;
    lane_ctr_init[95:64] = 32'hFFFF_FFFE; lane_load = 4'b0100;
    mctr[2] = 32'hFFFF_FFFE;
    @(negedge clk);
    lane_load = '0;
    push_exp(2, 1'b0);
    push_exp(2, 1'b0);
    req = 4'b0100;
    for (int b = 0; b < 2; b++) begin
      wait_resp(ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok) $display("FAIL wrap_resp: no resp_valid within bound");
      else if ({resp_lane, resp_ctr, resp_err, resp_data} !== {e.lane, e.ctr, e.err, e.data})
        $display("FAIL wrap_resp: got lane=%0d ctr=%h err=%b expected lane=%0d ctr=%h err=%b",
                 resp_lane, resp_ctr, resp_err, e.lane, e.ctr, e.err);
      else n_pass++;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (exhausted !== 4'b0100) $display("FAIL exhausted_set: got %b expected 0100", exhausted);
    else n_pass++;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ks_cfg_we || busy) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL exhausted_blocks: got grant=1 expected grant=0");
    else n_pass++;
    lane_ctr_init[95:64] = '0; lane_load = 4'b0100;
    mctr[2] = '0;
    push_exp(2, 1'b0);
    @(negedge clk);
    lane_load = '0;
    n_checks++;
    if (exhausted !== 4'b0000) $display("FAIL exhausted_clear: got %b expected 0000", exhausted);
    else n_pass++;
    wait_resp(ok);
    e = sb.pop_front();
    req = '0;
    n_checks++;
    if (!ok) $display("FAIL reload_resp: no resp_valid within bound");
    else if ({resp_lane, resp_ctr, resp_err, resp_data} !== {e.lane, e.ctr, e.err, e.data})
      $display("FAIL reload_resp: got lane=%0d ctr=%h err=%b expected lane=%0d ctr=%h err=%b",
               resp_lane, resp_ctr, resp_err, e.lane, e.ctr, e.err);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok, got;
    int cnt;
    stub_en = 1'b0;
    push_exp(0, 1'b1);
    req = 4'b0001;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (ks_req) ok = 1'b1;
    end
    cnt = 0; got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      cnt++;
      if (resp_valid) got = 1'b1;
    end
    n_checks++;
    if (!ok || !got || cnt != TMO)
      $display("FAIL tmo_latency: got req_seen=%b resp_seen=%b cycles=%0d expected cycles=%0d", ok, got, cnt, TMO);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({resp_lane, resp_ctr, resp_err, resp_data} !== {e.lane, e.ctr, e.err, e.data})
      $display("FAIL tmo_resp: got lane=%0d ctr=%h err=%b data_lo=%h expected lane=%0d ctr=%h err=%b data_lo=%h",
               resp_lane, resp_ctr, resp_err, resp_data[31:0], e.lane, e.ctr, e.err, e.data[31:0]);
    else n_pass++;
    stub_en = 1'b1;
    push_exp(0, 1'b0);
    wait_resp(ok);
    e = sb.pop_front();
    req = '0;
    n_checks++;
    if (!ok) $display("FAIL tmo_retry: no resp_valid within bound");
    else if ({resp_lane, resp_ctr, resp_err, resp_data} !== {e.lane, e.ctr, e.err, e.data})
      $display("FAIL tmo_retry: got lane=%0d ctr=%h err=%b expected lane=%0d ctr=%h err=%b",
               resp_lane, resp_ctr, resp_err, e.lane, e.ctr, e.err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    req = 4'b0010;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (ks_req) ok = 1'b1;
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b0; req = '0;
    @(negedge clk);
    n_checks++;
    if (!ok || {busy, ks_req, ks_cfg_we, resp_valid} !== 4'b0)
      $display("FAIL reset_mid: got req_seen=%b busy=%b ks_req=%b cfg_we=%b resp_valid=%b expected 1,0,0,0,0",
               ok, busy, ks_req, ks_cfg_we, resp_valid);
    else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) mctr[i] = '0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (resp_valid || busy) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL reset_mid_quiet: got activity=1 expected activity=0");
    else n_pass++;
    push_exp(0, 1'b0);
    req = 4'b0011;
    wait_resp(ok);
    e = sb.pop_front();
    req = '0;
    n_checks++;
    if (!ok) $display("FAIL post_reset_grant: no resp_valid within bound");
    else if ({resp_lane, resp_ctr, resp_err, resp_data} !== {e.lane, e.ctr, e.err, e.data})
      $display("FAIL post_reset_grant: got lane=%0d ctr=%h err=%b expected lane=%0d ctr=%h err=%b",
               resp_lane, resp_ctr, resp_err, e.lane, e.ctr, e.err);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; lane_load = '0; lane_ctr_init = '0; stub_en = 1'b1;
    key = 256'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
    for (int i = 0; i < N; i++)
      lane_nonce[96*i +: 96] = {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i),
                                32'h1357_0000 + 32'(i) * 32'h0101_0101};
    test_reset();
    test_single_lane();
    test_round_robin();
    test_exhaust();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
